riscv_mini_sequencer: RTL and testbench

//   Host-side driver for the riscv_mini core's instruction port. Receives a program as a byte

---
 rtl/riscv_mini_sequencer_pkg.sv | 45 ++++
 rtl/riscv_mini_sequencer_if.sv | 33 +++
 rtl/riscv_mini_sequencer_prog_mem.sv | 24 ++
 rtl/riscv_mini_sequencer.sv | 143 ++++++++++++++
 tb/tb_riscv_mini_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_mini_sequencer_pkg.sv
// Shared definitions for the riscv_mini instruction sequencer.
//   - opcode / funct3 codes of the 16-bit riscv_mini instruction word
//     (opcode in [1:0], funct3 in [15:13])
//   - NOP constant driven whenever nothing is issued
//   - sequencer state enum and instruction-class helpers
package riscv_mini_sequencer_pkg;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_L = 2'b10;
  localparam logic [1:0] OP_X = 2'b11;

  localparam logic [2:0] F3_OUT = 3'b000;
  localparam logic [2:0] F3_CMP = 3'b011;
  localparam logic [2:0] F3_ALU = 3'b111;

  // opcode X, funct3 001: writes no register and makes the core output 0.
  localparam logic [15:0] INSTR_NOP = 16'h2003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic [1:0] instr_op(input logic [15:0] i);
    return i[1:0];
  endfunction

  function automatic logic [2:0] instr_f3(input logic [15:0] i);
    return i[15:13];
  endfunction

  // Compare: a true result (bit 0) makes the sequencer skip the next instruction.
  function automatic logic is_cmp(input logic [15:0] i);
    return (instr_op(i) == OP_X) && (instr_f3(i) == F3_CMP);
  endfunction

  // Instructions whose core result is an observable output value.
  function automatic logic is_capture(input logic [15:0] i);
    return (instr_op(i) == OP_X) &&
           ((instr_f3(i) == F3_OUT) || (instr_f3(i) == F3_CMP) || (instr_f3(i) == F3_ALU));
  endfunction

endpackage

// File: rtl/riscv_mini_sequencer_if.sv
// Host/core-facing bundle of the sequencer.
//   master : host + core side (drives load stream, start/clear, core result)
//   slave  : the sequencer itself
interface riscv_mini_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic             clear;
  logic             load_valid;
  logic [7:0]       load_byte;
  logic             start;
  logic [15:0]      instr_out;
  logic             instr_valid;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] result_out;
  logic             result_valid;
  logic [PW-1:0]    pc_out;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output clear, load_valid, load_byte, start, core_result,
    input  instr_out, instr_valid, result_out, result_valid, pc_out, busy, done, overflow
  );

  modport slave (
    input  clear, load_valid, load_byte, start, core_result,
    output instr_out, instr_valid, result_out, result_valid, pc_out, busy, done, overflow
  );
endinterface

// File: rtl/riscv_mini_sequencer_prog_mem.sv
// Program buffer: DEPTH x 16-bit, one synchronous write port, one
// asynchronous read port. No reset; contents are only meaningful below len.
//   clk            clock
//   we/waddr/wdata write port (sampled on rising clk)
//   raddr/rdata    combinational read port
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/riscv_mini_sequencer.sv
// riscv_mini_sequencer: host-side driver for the riscv_mini instruction port.
// Assembles a little-endian byte stream into 16-bit instructions, then issues
// one instruction per cycle, using the core's combinational result to capture
// outputs and to skip the instruction after a true compare.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : riscv_mini_sequencer_if.slave
//     clear/load_valid/load_byte/start/core_result in
//     instr_out/instr_valid/result_out/result_valid/pc_out/busy/done/overflow out
module riscv_mini_sequencer
  import riscv_mini_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  riscv_mini_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;   // one spare bit so pc = DEPTH+1 cannot wrap

  state_t           state, state_n;
  logic [PW-1:0]    pc, len, pc_step;
  logic             half;
  logic [7:0]       low_byte;
  logic [15:0]      instr_q;
  logic             instr_vld_q;
  logic [WIDTH-1:0] res_q;
  logic             res_vld_q;
  logic             ovf_q;
  logic             issue_n, capture, wr_en;
  logic [AW-1:0]    rd_addr;
  logic [15:0]      rd_data;

  seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (len[AW-1:0]),
    .wdata ({bus.load_byte, low_byte}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // pc indexes the instruction currently on instr_out. The skip decision needs
  // the core's result for that instruction, so the next fetch address is
  // computed combinationally inside the issue cycle: no bubbles.
  always_comb begin
    state_n = state;
    pc_step = pc + PW'(1);
    issue_n = 1'b0;
    rd_addr = '0;
    capture = instr_vld_q && is_capture(instr_q);
    if (instr_vld_q && is_cmp(instr_q) && bus.core_result[0]) pc_step = pc + PW'(2);
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_n = ST_RUN;
          issue_n = (len != '0);
        end
      end
      ST_RUN: begin
        // >= rather than == since a skip can land one past len
        if (instr_vld_q && (pc_step < len)) begin
          issue_n = 1'b1;
          rd_addr = pc_step[AW-1:0];
        end else begin
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    wr_en = (state == ST_IDLE) && !bus.clear && !bus.start && bus.load_valid && half;
    if (bus.clear) begin
      state_n = ST_IDLE;
      issue_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      len         <= '0;
      half        <= 1'b0;
      low_byte    <= '0;
      instr_q     <= INSTR_NOP;
      instr_vld_q <= 1'b0;
      res_q       <= '0;
      res_vld_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      instr_q     <= issue_n ? rd_data : INSTR_NOP;
      instr_vld_q <= issue_n;
      res_vld_q   <= 1'b0;
      // sampled on the same edge the core writes back
      if (capture && !bus.clear) begin
        res_q     <= bus.core_result;
        res_vld_q <= 1'b1;
      end
      if (bus.clear) begin
        pc    <= '0;
        len   <= '0;
        half  <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (bus.start) begin
              pc   <= '0;
              half <= 1'b0;   // an odd trailing byte is discarded
            end else if (bus.load_valid) begin
              if (half) begin
                len  <= len + PW'(1);
                half <= 1'b0;
              end else if (len == PW'(DEPTH)) begin
                ovf_q <= 1'b1;
              end else begin
                low_byte <= bus.load_byte;
                half     <= 1'b1;
              end
            end
          end
          ST_RUN:  if (instr_vld_q) pc <= pc_step;
          ST_DONE: if (bus.start) pc <= '0;
          default: ;
        endcase
      end
    end
  end

  assign bus.instr_out    = instr_q;
  assign bus.instr_valid  = instr_vld_q;
  assign bus.result_out   = res_q;
  assign bus.result_valid = res_vld_q;
  assign bus.pc_out       = pc;
  assign bus.busy         = (state == ST_RUN);
  assign bus.done         = (state == ST_DONE);
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_riscv_mini_sequencer.sv
module tb_riscv_mini_sequencer;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] watch_instr = 16'h0000;
  logic [7:0]  watch_val = 8'h00;

  always #5 clk = ~clk;

  riscv_mini_sequencer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  riscv_mini_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // core model: result only for the watched instruction
  assign bus.core_result = (bus.instr_out == watch_instr) ? watch_val : 8'h00;

  task automatic load_b(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic load_w(input logic [15:0] w);
    load_b(w[7:0]);
    load_b(w[15:8]);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.instr_out !== 16'h2003) begin n_bad++; $display("FAIL rst_instr: got %h exp 2003", bus.instr_out); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ivalid: got %b exp 0", bus.instr_valid); end
    n_cmp++; if (bus.result_out !== 8'h00 || bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_result: got %h/%b exp 00/0", bus.result_out, bus.result_valid); end
    n_cmp++; if (bus.pc_out !== 5'd0) begin n_bad++; $display("FAIL rst_pc: got %0d exp 0", bus.pc_out); end
    n_cmp++; if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b exp 000", {bus.busy, bus.done, bus.overflow}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] exp_i [3];
    exp_i[0] = 16'h0101; exp_i[1] = 16'h0202; exp_i[2] = 16'h0303;
    watch_instr = 16'h0303; watch_val = 8'h77;
    do_clear();
    for (int i = 0; i < 3; i++) load_w(exp_i[i]);
    do_start();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.instr_out !== exp_i[i] || bus.instr_valid !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_issue%0d: got %h v%b b%b exp %h v1 b1", i, bus.instr_out, bus.instr_valid, bus.busy, exp_i[i]); end
      @(negedge clk);
    end
    n_cmp++; if (bus.done !== 1'b1 || bus.instr_out !== 16'h2003 || bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL basic_done: got d%b %h v%b exp d1 2003 v0", bus.done, bus.instr_out, bus.instr_valid); end
    n_cmp++; if (bus.pc_out !== 5'd3) begin n_bad++; $display("FAIL basic_pc: got %0d exp 3", bus.pc_out); end
    n_cmp++; if (bus.result_out !== 8'h77 || bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL basic_capture: got %h/%b exp 77/1", bus.result_out, bus.result_valid); end
  endtask

  task automatic test_skip();
    watch_instr = 16'h6003; watch_val = 8'h01;
    do_clear();
    load_w(16'h6003); load_w(16'h0101); load_w(16'h0202);
    do_start();
    n_cmp++; if (bus.instr_out !== 16'h6003 || bus.pc_out !== 5'd0) begin n_bad++; $display("FAIL skip_cmp: got %h pc%0d exp 6003 pc0", bus.instr_out, bus.pc_out); end
    @(negedge clk);
    n_cmp++; if (bus.instr_out !== 16'h0202 || bus.instr_valid !== 1'b1 || bus.pc_out !== 5'd2) begin n_bad++; $display("FAIL skip_b: got %h v%b pc%0d exp 0202 v1 pc2", bus.instr_out, bus.instr_valid, bus.pc_out); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.pc_out !== 5'd3) begin n_bad++; $display("FAIL skip_end: got d%b pc%0d exp d1 pc3", bus.done, bus.pc_out); end
    // rerun from DONE with a false compare
    watch_val = 8'h00;
    do_start();
    n_cmp++; if (bus.instr_out !== 16'h6003 || bus.pc_out !== 5'd0) begin n_bad++; $display("FAIL noskip_cmp: got %h pc%0d exp 6003 pc0", bus.instr_out, bus.pc_out); end
    @(negedge clk);
    n_cmp++; if (bus.instr_out !== 16'h0101 || bus.pc_out !== 5'd1) begin n_bad++; $display("FAIL noskip_a: got %h pc%0d exp 0101 pc1", bus.instr_out, bus.pc_out); end
    @(negedge clk);
    n_cmp++; if (bus.instr_out !== 16'h0202 || bus.pc_out !== 5'd2) begin n_bad++; $display("FAIL noskip_b: got %h pc%0d exp 0202 pc2", bus.instr_out, bus.pc_out); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.pc_out !== 5'd3) begin n_bad++; $display("FAIL noskip_end: got d%b pc%0d exp d1 pc3", bus.done, bus.pc_out); end
  endtask

  task automatic test_output();
    watch_instr = 16'h0003; watch_val = 8'h5A;
    do_clear();
    load_w(16'h0003);
    do_start();
    n_cmp++; if (bus.instr_out !== 16'h0003 || bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL out_issue: got %h rv%b exp 0003 rv0", bus.instr_out, bus.result_valid); end
    @(negedge clk);
    n_cmp++; if (bus.result_out !== 8'h5A || bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL out_capture: got %h/%b exp 5a/1", bus.result_out, bus.result_valid); end
    @(negedge clk);
    n_cmp++; if (bus.result_out !== 8'h5A || bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL out_pulse: got %h/%b exp 5a/0", bus.result_out, bus.result_valid); end
  endtask

  task automatic test_overflow();
    watch_instr = 16'h0000; watch_val = 8'h00;
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_w({8'(i + 16), 8'h41});
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b exp 0", bus.overflow); end
    load_b(8'hFF); load_b(8'hFF);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b exp 1", bus.overflow); end
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (bus.instr_out !== {8'(i + 16), 8'h41} || bus.instr_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_buf%0d: got %h v%b exp %h v1", i, bus.instr_out, bus.instr_valid, {8'(i + 16), 8'h41}); end
      @(negedge clk);
    end
    n_cmp++; if (bus.done !== 1'b1 || bus.pc_out !== 5'd16 || bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_end: got d%b pc%0d o%b exp d1 pc16 o1", bus.done, bus.pc_out, bus.overflow); end
    do_clear();
    n_cmp++; if (bus.overflow !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got o%b d%b exp o0 d0", bus.overflow, bus.done); end
  endtask

  // relies on len==0 left by the preceding clear
  task automatic test_empty();
    do_start();
    n_cmp++; if (bus.busy !== 1'b1 || bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL empty_run: got b%b v%b exp b1 v0", bus.busy, bus.instr_valid); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL empty_done: got b%b d%b v%b exp b0 d1 v0", bus.busy, bus.done, bus.instr_valid); end
  endtask

  task automatic test_odd();
    do_clear();
    load_w(16'h0101); load_b(8'hAA);
    do_start();
    n_cmp++; if (bus.instr_out !== 16'h0101 || bus.instr_valid !== 1'b1) begin n_bad++; $display("FAIL odd_issue: got %h v%b exp 0101 v1", bus.instr_out, bus.instr_valid); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.pc_out !== 5'd1 || bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL odd_done: got d%b pc%0d v%b exp d1 pc1 v0", bus.done, bus.pc_out, bus.instr_valid); end
  endtask

  task automatic test_reset_mid_run();
    watch_instr = 16'h0003; watch_val = 8'hC3;
    do_clear();
    load_w(16'h0003); load_w(16'h0101); load_w(16'h0202);
    do_start();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1 || bus.result_out !== 8'hC3) begin n_bad++; $display("FAIL mid_pre: got b%b r%h exp b1 rc3", bus.busy, bus.result_out); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.instr_out !== 16'h2003 || bus.instr_valid !== 1'b0 || bus.pc_out !== 5'd0) begin n_bad++; $display("FAIL mid_rst_issue: got b%b %h v%b pc%0d exp b0 2003 v0 pc0", bus.busy, bus.instr_out, bus.instr_valid, bus.pc_out); end
    n_cmp++; if (bus.result_out !== 8'h00 || bus.result_valid !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_result: got %h rv%b d%b exp 00 rv0 d0", bus.result_out, bus.result_valid, bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    n_cmp++; if (bus.busy !== 1'b1 || bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_restart: got b%b v%b exp b1 v0", bus.busy, bus.instr_valid); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_restart_done: got d%b v%b exp d1 v0", bus.done, bus.instr_valid); end
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte = 8'h00;
    bus.start = 1'b0;
    test_reset();
    test_basic();
    test_skip();
    test_output();
    test_overflow();
    test_empty();
    test_odd();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
